regfile_wb_sched: RTL and testbench
===================================

# regfile_wb_sched

Write-back scheduler and scoreboard for the 32×32 register file. Shares the register file's single write port between the ALU and load/store write-back sources using round-robin arbitration, and tracks which registers have an in-flight write so the issue stage can stall on RAW/WAW hazards. Sits between the execute/memory stages and the register file's RegWrite/Wreg/Wdata inputs.

## Interface
- XLEN, 32: data width of write-back values.
- NREG, 32: architectural register count; index width is $clog2(NREG) = 5.

- CLK  in  1  clock; all state updates on posedge.
- RST_N  in  1  reset, synchronous, active-low.
- iss_valid  in  1  the issue stage presents an instruction.
- iss_rs1, iss_rs2  in  5  source registers of the presented instruction.
- iss_rd  in  5  destination register; 0 means no write-back.
- iss_stall  out  1  the instruction must not issue this cycle.
- alu_valid  in  1  ALU write-back request.
- alu_rd  in  5  destination register of the ALU write-back.
- alu_data  in  XLEN  ALU write-back data.
- alu_ready  out  1  ALU request accepted this cycle.
- mem_valid, mem_rd, mem_data, mem_ready: the same four signals for the load write-back source.
- RegWrite  out  1  register-file write enable (registered).
- Wreg  out  5  register-file write index (registered).
- Wdata  out  XLEN  register-file write data (registered).
- pend_mask  out  NREG  pending-write bitmap; bit 0 is always 0.
- pend_cnt  out  6  population count of pend_mask (registered).
- wb_err  out  1  sticky: a write-back targeted a register that had no pending write.

## Operation
- Scoreboard:
  - pend[r] is set when iss_valid && !iss_stall && iss_rd != 0.
  - pend[r] is cleared on the edge where RegWrite=1 and Wreg=r.
  - iss_stall = iss_valid && (pend[rs1] || pend[rs2] || pend[rd]); bits for x0 are ignored. WAW also stalls.
  - Set and clear of the same register in one cycle cannot occur, because a WAW hazard stalls issue. If it does occur, set wins.
- Arbitration:
  - A one-bit pointer `last` holds the source granted most recently.
  - One source valid: that source is granted.
  - Both sources valid: the source that is not `last` is granted.
  - On a grant, `last` is updated to the granted source.
  - alu_ready/mem_ready are combinational grant signals. At most one is high per cycle, and neither is high without the corresponding valid.
- Handshake:
  - A source holds valid, rd and data stable until it sees ready.
  - A transfer completes in a cycle where valid && ready.
- Write port:
  - The granted request is registered into RegWrite/Wreg/Wdata at the next edge.
  - With no grant, RegWrite=0 and Wreg/Wdata hold their previous values.
  - A granted request with rd=0 is accepted and discarded: RegWrite=0 and wb_err is unaffected.
- Error: wb_err is set at the edge that registers a grant whose rd != 0 while pend[rd]=0. It clears only on reset.
- pend_cnt is recomputed from the next-state mask each cycle, range 0..31.

## Timing
- Reset (RST_N low at a posedge):
  - pend = 0, pend_cnt = 0, RegWrite = 0, Wreg = 0, Wdata = 0, wb_err = 0.
  - `last` is set to MEM, so ALU wins the first tie.
  - While RST_N is low, alu_ready, mem_ready and iss_stall are forced to 0.
  - Any grant in flight during a mid-operation reset is dropped; it is not written.
- iss_stall is combinational from iss_* and pend, with 0-cycle latency.
- Grant to RegWrite: 1 cycle. In cycle N, valid&&ready; in cycle N+1, RegWrite=1; the register file captures at the end of N+1.
- The pending bit clears on the same edge the register file captures. A dependent instruction can therefore issue no earlier than cycle N+2 and reads the new value combinationally.
- Throughput: one write-back per cycle. Under continuous dual requests the sources alternate strictly.
- Issue of a new writer to r and retirement of a different register in the same cycle update pend and pend_cnt independently.

## Structure
- Package regfile_sched_pkg holds:
  - typedef enum logic {SRC_ALU, SRC_MEM} wb_src_t;
  - REG_IDX_W = 5;
  - the x0 constant.
- Sub-module rr_arb2: a 2-requester round-robin arbiter containing the `last` flop, with req[1:0] → gnt[1:0].
- Scoreboard, write-port registers and popcount are implemented in the top module.

## Test plan
- Reset: drive RST_N=0 for 2 cycles with alu_valid=1 → RegWrite=0, pend_mask=0, alu_ready=0; after release, ALU is granted first.
- RAW stall: issue rd=5, then present rs1=5 → iss_stall=1 until the cycle after RegWrite=1 with Wreg=5; the issue proceeds in cycle N+2.
- Tie alternation: 4 cycles of alu_valid=mem_valid=1 with rd 1/2 → grants ALU, MEM, ALU, MEM; Wreg/Wdata match each grant one cycle later.
- x0 write: alu_rd=0 with data 0xDEADBEEF → alu_ready=1, RegWrite stays 0, wb_err=0; iss_rd=0 never sets pend.
- Spurious write: mem write-back to rd=7 with pend[7]=0 → RegWrite=1 with Wreg=7, and wb_err=1 sticky until reset.
- Count: issue rd=1..31 with no write-backs → pend_cnt=31; retire all 31 → pend_cnt=0, pend_mask=0.

Source files
------------

// File: rtl/regfile_sched_pkg.sv
// Shared types and constants for the register-file write-back scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_sched_pkg;

  localparam int REG_IDX_W = 5;
  localparam int CNT_W     = 6;

  // Register x0 is hard-wired to zero, so it is never tracked or written.
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  // Write-back source identifiers; the value doubles as the grant bit index.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter holding the most-recently-granted pointer.
// Latency: grant is combinational from req_i; the pointer updates at the next edge.
// Backpressure: the loser of a tie simply keeps requesting; grants are forced low in reset.
// Ports: clk_i, rst_n_i (sync, active-low), req_i[1:0] (bit0 ALU, bit1 MEM), gnt_o[1:0] one-hot or zero.
module rr_arb2
  import regfile_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  wb_src_t last_q;
  wb_src_t last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    if (rst_n_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        // On a tie the source that did not win last time goes next.
        2'b11:   gnt_o = (last_q == SRC_MEM) ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
      if (gnt_o[0]) begin
        last_d = SRC_ALU;
      end else if (gnt_o[1]) begin
        last_d = SRC_MEM;
      end
    end
  end

  // Resetting to MEM lets the ALU win the first tie.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      last_q <= SRC_MEM;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler + pending-write scoreboard in front of the register file write port.
// Latency: grant -> RegWrite/Wreg/Wdata 1 cycle; iss_stall combinational; pend_cnt registered.
// Backpressure: alu_ready/mem_ready are round-robin grants; sources hold their request until ready.
// Ports: CLK, RST_N (sync, active-low); iss_* issue-stage hazard query; alu_*/mem_* write-back
//        requests; RegWrite/Wreg/Wdata to the register file; pend_mask/pend_cnt/wb_err status.
module regfile_wb_sched
  import regfile_sched_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 iss_valid,
  input  logic [REG_IDX_W-1:0] iss_rs1,
  input  logic [REG_IDX_W-1:0] iss_rs2,
  input  logic [REG_IDX_W-1:0] iss_rd,
  output logic                 iss_stall,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [REG_IDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]      mem_data,
  output logic                 mem_ready,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] Wreg,
  output logic [XLEN-1:0]      Wdata,
  output logic [NREG-1:0]      pend_mask,
  output logic [CNT_W-1:0]     pend_cnt,
  output logic                 wb_err
);

  logic [NREG-1:0]      pend_q, pend_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 regwrite_q, regwrite_d;
  logic [REG_IDX_W-1:0] wreg_q, wreg_d;
  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic                 err_q, err_d;

  logic [1:0]           gnt;
  logic                 gnt_any;
  logic [REG_IDX_W-1:0] gnt_rd;
  logic [XLEN-1:0]      gnt_data;
  logic                 issue_set;
  logic [NREG-1:0]      set_vec, clr_vec;

  rr_arb2 u_arb (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .req_i   ({mem_valid, alu_valid}),
    .gnt_o   (gnt)
  );

  assign alu_ready = gnt[SRC_ALU];
  assign mem_ready = gnt[SRC_MEM];
  assign gnt_any   = |gnt;
  assign gnt_rd    = gnt[SRC_MEM] ? mem_rd   : alu_rd;
  assign gnt_data  = gnt[SRC_MEM] ? mem_data : alu_data;

  // pend_q[0] is never set, so x0 sources/destinations can never cause a stall.
  // The rd check makes a second writer to an in-flight register wait (WAW).
  assign iss_stall = RST_N && iss_valid &&
                     (pend_q[iss_rs1] || pend_q[iss_rs2] || pend_q[iss_rd]);
  assign issue_set = RST_N && iss_valid && !iss_stall && (iss_rd != REG_X0);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_set) begin
      set_vec[iss_rd] = 1'b1;
    end
    // Retire on the same edge the register file captures the write.
    if (regwrite_q) begin
      clr_vec[wreg_q] = 1'b1;
    end
    // Set applied after clear so a simultaneous set/clear leaves the bit pending.
    pend_d    = (pend_q & ~clr_vec) | set_vec;
    pend_d[0] = 1'b0;

    cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_d = cnt_d + CNT_W'(pend_d[i]);
    end
  end

  always_comb begin
    regwrite_d = 1'b0;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    // A grant to x0 completes the handshake but is dropped here.
    if (gnt_any && (gnt_rd != REG_X0)) begin
      regwrite_d = 1'b1;
      wreg_d     = gnt_rd;
      wdata_d    = gnt_data;
      if (!pend_q[gnt_rd]) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pend_q     <= '0;
      cnt_q      <= '0;
      regwrite_q <= 1'b0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      regwrite_q <= regwrite_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign RegWrite  = regwrite_q;
  assign Wreg      = wreg_q;
  assign Wdata     = wdata_q;
  assign pend_mask = pend_q;
  assign pend_cnt  = cnt_q;
  assign wb_err    = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: per-cycle vector table plus reset and fill/drain sequences.
// Latency: inputs driven on negedge, combinational outputs checked 1ns later, registered outputs 1ns after posedge.
// Backpressure: request sources hold their request until the bench sees ready.
module tb_regfile_wb_sched;

  logic        CLK;
  logic        RST_N;
  logic        iss_valid;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        RegWrite;
  logic [4:0]  Wreg;
  logic [31:0] Wdata;
  logic [31:0] pend_mask;
  logic [5:0]  pend_cnt;
  logic        wb_err;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_sched dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .iss_valid (iss_valid),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_stall (iss_stall),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_rd    (mem_rd),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .RegWrite  (RegWrite),
    .Wreg      (Wreg),
    .Wdata     (Wdata),
    .pend_mask (pend_mask),
    .pend_cnt  (pend_cnt),
    .wb_err    (wb_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        iv;
    logic [4:0]  rs1, rs2, rd;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        e_ardy, e_mrdy, e_stall;
    logic        e_rw;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdat;
    logic [5:0]  e_cnt;
    logic        e_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
  endtask

  initial begin
    // Cycle table after reset. Columns:
    //  iss_valid rs1 rs2 rd | alu v rd data | mem v rd data | alu_rdy mem_rdy stall | RW Wreg Wdata cnt err
    vecs[0]  = '{1'b1, 5'd0, 5'd0, 5'd1,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0,  1'b0, 5'd0, 32'h0,        6'd1, 1'b0};
    vecs[1]  = '{1'b1, 5'd0, 5'd0, 5'd2,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0,  1'b0, 5'd0, 32'h0,        6'd2, 1'b0};
    vecs[2]  = '{1'b1, 5'd0, 5'd0, 5'd3,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0,  1'b0, 5'd0, 32'h0,        6'd3, 1'b0};
    vecs[3]  = '{1'b1, 5'd0, 5'd0, 5'd4,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0,  1'b0, 5'd0, 32'h0,        6'd4, 1'b0};
    // Tie: ALU first; RAW on x1 stalls.
    vecs[4]  = '{1'b1, 5'd1, 5'd0, 5'd9,  1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222,
                 1'b1, 1'b0, 1'b1,  1'b1, 5'd1, 32'h11111111, 6'd4, 1'b0};
    // Tie: MEM; x1 still pending until this edge.
    vecs[5]  = '{1'b1, 5'd1, 5'd0, 5'd9,  1'b1, 5'd3, 32'h33333333, 1'b1, 5'd2, 32'h22222222,
                 1'b0, 1'b1, 1'b1,  1'b1, 5'd2, 32'h22222222, 6'd3, 1'b0};
    // Tie: ALU; dependent issues at N+2 and sets x9.
    vecs[6]  = '{1'b1, 5'd1, 5'd0, 5'd9,  1'b1, 5'd3, 32'h33333333, 1'b1, 5'd4, 32'h44444444,
                 1'b1, 1'b0, 1'b0,  1'b1, 5'd3, 32'h33333333, 6'd3, 1'b0};
    // Tie: MEM (ALU request to x0 waits).
    vecs[7]  = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd4, 32'h44444444,
                 1'b0, 1'b1, 1'b0,  1'b1, 5'd4, 32'h44444444, 6'd2, 1'b0};
    // x0 write-back is accepted but not written; iss_rd=0 sets nothing.
    vecs[8]  = '{1'b1, 5'd0, 5'd0, 5'd0,  1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0,  1'b0, 5'd4, 32'h44444444, 6'd1, 1'b0};
    vecs[9]  = '{1'b1, 5'd0, 5'd9, 5'd0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b1,  1'b0, 5'd4, 32'h44444444, 6'd1, 1'b0};
    // Spurious MEM write to x7; WAW on x9 stalls.
    vecs[10] = '{1'b1, 5'd0, 5'd0, 5'd9,  1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h77777777,
                 1'b0, 1'b1, 1'b1,  1'b1, 5'd7, 32'h77777777, 6'd1, 1'b1};
    vecs[11] = '{1'b0, 5'd0, 5'd0, 5'd0,  1'b1, 5'd9, 32'h99999999, 1'b0, 5'd0, 32'h0,
                 1'b1, 1'b0, 1'b0,  1'b1, 5'd9, 32'h99999999, 6'd1, 1'b1};
    vecs[12] = '{1'b1, 5'd9, 5'd0, 5'd0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b1,  1'b0, 5'd9, 32'h99999999, 6'd0, 1'b1};
    vecs[13] = '{1'b1, 5'd9, 5'd0, 5'd5,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,
                 1'b0, 1'b0, 1'b0,  1'b0, 5'd9, 32'h99999999, 6'd1, 1'b1};

    // ---------------- Reset with a request held ----------------
    idle_inputs();
    RST_N = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5A5A5;
    repeat (2) begin
      @(posedge CLK); #1;
      chk("rst_regwrite", {31'd0, RegWrite}, 32'd0);
      chk("rst_pend_mask", pend_mask, 32'd0);
      chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
    end
    chk("rst_pend_cnt", {26'd0, pend_cnt}, 32'd0);
    chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
    chk("rst_wreg", {27'd0, Wreg}, 32'd0);
    chk("rst_wdata", Wdata, 32'd0);

    @(negedge CLK);
    RST_N = 1'b1;
    mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h5A5A5A5A;
    #1;
    chk("first_tie_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("first_tie_mem_ready", {31'd0, mem_ready}, 32'd0);
    @(posedge CLK); #1;
    chk("first_tie_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("first_tie_wdata", Wdata, 32'hA5A5A5A5);
    chk("first_tie_err", {31'd0, wb_err}, 32'd1);
    @(negedge CLK);
    idle_inputs();
    @(posedge CLK); #1;
    chk("err_sticky", {31'd0, wb_err}, 32'd1);
    chk("idle_regwrite", {31'd0, RegWrite}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    chk("err_clear_rst", {31'd0, wb_err}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // ---------------- Vector table ----------------
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      iss_valid = vecs[i].iv;  iss_rs1 = vecs[i].rs1; iss_rs2 = vecs[i].rs2; iss_rd = vecs[i].rd;
      alu_valid = vecs[i].av;  alu_rd = vecs[i].ard;  alu_data = vecs[i].adat;
      mem_valid = vecs[i].mv;  mem_rd = vecs[i].mrd;  mem_data = vecs[i].mdat;
      #1;
      chk($sformatf("v%0d_alu_ready", i), {31'd0, alu_ready}, {31'd0, vecs[i].e_ardy});
      chk($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, vecs[i].e_mrdy});
      chk($sformatf("v%0d_iss_stall", i), {31'd0, iss_stall}, {31'd0, vecs[i].e_stall});
      @(posedge CLK); #1;
      chk($sformatf("v%0d_regwrite", i), {31'd0, RegWrite}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_wreg", i), {27'd0, Wreg}, {27'd0, vecs[i].e_wreg});
      chk($sformatf("v%0d_wdata", i), Wdata, vecs[i].e_wdat);
      chk($sformatf("v%0d_pend_cnt", i), {26'd0, pend_cnt}, {26'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d_wb_err", i), {31'd0, wb_err}, {31'd0, vecs[i].e_err});
    end

    // ---------------- Fill all 31 registers, then drain ----------------
    @(negedge CLK);
    idle_inputs();
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int r = 1; r < 32; r++) begin
      iss_valid = 1'b1; iss_rd = 5'(r);
      #1;
      chk($sformatf("fill%0d_stall", r), {31'd0, iss_stall}, 32'd0);
      @(negedge CLK);
    end
    iss_valid = 1'b0; iss_rd = '0;
    #1;
    chk("full_pend_cnt", {26'd0, pend_cnt}, 32'd31);
    chk("full_pend_mask", pend_mask, 32'hFFFFFFFE);

    alu_valid = 1'b1;
    for (int r = 1; r < 32; r++) begin
      alu_rd = 5'(r); alu_data = 32'(r) * 32'h01010101;
      #1;
      chk($sformatf("drain%0d_ready", r), {31'd0, alu_ready}, 32'd1);
      @(negedge CLK);
    end
    alu_valid = 1'b0;
    #1;
    chk("drain_last_wreg", {27'd0, Wreg}, 32'd31);
    chk("drain_last_wdata", Wdata, 32'h1F1F1F1F);
    @(posedge CLK);
    @(posedge CLK); #1;
    chk("empty_pend_cnt", {26'd0, pend_cnt}, 32'd0);
    chk("empty_pend_mask", pend_mask, 32'd0);
    chk("empty_wb_err", {31'd0, wb_err}, 32'd0);
    chk("empty_regwrite", {31'd0, RegWrite}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
